// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN feature-map datapath blocks.
package cnn_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned CH_DEF     = 3;

  typedef enum logic {
    FILL = 1'b0,
    READ = 1'b1
  } state_t;

  // Ceiling log2, never below 1 so a 1-entry memory still gets an address bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((64'd1 << width) < 64'(value)) width = width + 1;
    return width;
  endfunction

endpackage

// File: rtl/fmap_dp_ram.sv
// Simple dual-port synchronous RAM, one write port and one registered read port.
module fmap_dp_ram
  import cnn_pkg::*;
#(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 144,
  parameter int unsigned AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write and 1-cycle read; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_dout <= mem[rd_addr];
  end

endmodule

// File: rtl/fmap_window_buffer.sv
// Feature-map buffer: stores a full raster map, then replays it as KxK windows.
module fmap_window_buffer
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CH     = CH_DEF,
  parameter int unsigned MAP_W  = 12,
  parameter int unsigned MAP_H  = 12,
  parameter int unsigned K      = 5,
  parameter int unsigned STRIDE = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  input  logic                 i_wr_valid,
  input  logic [CH*DATA_W-1:0] i_wr_data,
  output logic                 o_wr_ready,
  output logic [CH*DATA_W-1:0] o_rd_data,
  output logic                 o_rd_valid,
  input  logic                 i_rd_ready,
  output logic                 o_rd_last,
  output logic                 o_rd_done,
  output logic                 o_busy
);

  localparam int unsigned WORD_W = CH * DATA_W;
  localparam int unsigned DEPTH  = MAP_W * MAP_H;
  localparam int unsigned AW     = clog2(DEPTH);
  localparam int unsigned OUT_W  = (MAP_W - K) / STRIDE + 1;
  localparam int unsigned OUT_H  = (MAP_H - K) / STRIDE + 1;

  // Reject kernels larger than the map and a zero stride at elaboration.
  if (K < 1 || K > MAP_W || K > MAP_H || STRIDE < 1) begin : g_bad_params
    $error("fmap_window_buffer: illegal K/STRIDE for the map size");
  end

  state_t            state, state_nx;
  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     oy, ox, ky, kx;
  logic              issue_done;
  logic              wr_en_c, issue_c, done_c, pop_c, room_c, last_tag_c;
  logic [1:0]        occupancy_c;
  logic [AW-1:0]     row_c, col_c, rd_addr_c;
  logic              inflight, inflight_last;
  logic [WORD_W-1:0] ram_dout;
  logic [WORD_W-1:0] skid_data;
  logic              skid_last, skid_valid;

  // Window element address and end-of-window tag for the current counters.
  assign row_c      = AW'(oy * AW'(STRIDE)) + ky;
  assign col_c      = AW'(ox * AW'(STRIDE)) + kx;
  assign rd_addr_c  = AW'(row_c * AW'(MAP_W)) + col_c;
  assign last_tag_c = (kx == AW'(K - 1)) && (ky == AW'(K - 1));

  // Elements held or on their way: output slot, skid slot and the RAM read in flight.
  assign pop_c       = o_rd_valid && i_rd_ready;
  assign occupancy_c = 2'(o_rd_valid) + 2'(skid_valid) + 2'(inflight);
  assign room_c      = (occupancy_c < 2'd2) || ((occupancy_c == 2'd2) && pop_c);

  // Next state, write enable, read issue and completion detect; flush overrides all.
  always_comb begin
    state_nx = state;
    wr_en_c  = 1'b0;
    issue_c  = 1'b0;
    done_c   = 1'b0;
    case (state)
      FILL: begin
        wr_en_c = i_wr_valid && o_wr_ready;
        if (wr_en_c && (wr_addr == AW'(DEPTH - 1))) state_nx = READ;
      end
      READ: begin
        issue_c = !issue_done && room_c;
        done_c  = issue_done && pop_c && !skid_valid && !inflight;
        if (done_c) state_nx = FILL;
      end
      default: state_nx = FILL;
    endcase
    if (i_flush) begin
      state_nx = FILL;
      wr_en_c  = 1'b0;
      issue_c  = 1'b0;
      done_c   = 1'b0;
    end
  end

  // State register with the status outputs derived from the next state.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= FILL;
      o_wr_ready <= 1'b1;
      o_busy     <= 1'b0;
      o_rd_done  <= 1'b0;
    end else begin
      state      <= state_nx;
      o_wr_ready <= (state_nx == FILL);
      o_busy     <= (state_nx == READ);
      o_rd_done  <= done_c;
    end
  end

  // Raster write pointer; wraps to 0 on the last word of the map.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_addr <= '0;
    end else if (i_flush) begin
      wr_addr <= '0;
    end else if (wr_en_c) begin
      wr_addr <= (wr_addr == AW'(DEPTH - 1)) ? '0 : wr_addr + AW'(1);
    end
  end

  // Window counters, kx innermost, oy outermost; stop after the final element.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      oy <= '0; ox <= '0; ky <= '0; kx <= '0;
      issue_done <= 1'b0;
    end else if (i_flush || done_c) begin
      oy <= '0; ox <= '0; ky <= '0; kx <= '0;
      issue_done <= 1'b0;
    end else if (issue_c) begin
      if (kx != AW'(K - 1)) begin
        kx <= kx + AW'(1);
      end else begin
        kx <= '0;
        if (ky != AW'(K - 1)) begin
          ky <= ky + AW'(1);
        end else begin
          ky <= '0;
          if (ox != AW'(OUT_W - 1)) begin
            ox <= ox + AW'(1);
          end else begin
            ox <= '0;
            if (oy != AW'(OUT_H - 1)) begin
              oy <= oy + AW'(1);
            end else begin
              oy         <= '0;
              issue_done <= 1'b1;
            end
          end
        end
      end
    end
  end

  // Read-in-flight tracking and 2-entry skid feeding the output register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      o_rd_valid    <= 1'b0;
      o_rd_data     <= '0;
      o_rd_last     <= 1'b0;
      skid_valid    <= 1'b0;
      skid_data     <= '0;
      skid_last     <= 1'b0;
    end else if (i_flush) begin
      inflight   <= 1'b0;
      o_rd_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      inflight      <= issue_c;
      inflight_last <= last_tag_c;
      if (pop_c || !o_rd_valid) begin
        if (skid_valid) begin
          o_rd_data  <= skid_data;
          o_rd_last  <= skid_last;
          o_rd_valid <= 1'b1;
          skid_valid <= inflight;
          if (inflight) begin
            skid_data <= ram_dout;
            skid_last <= inflight_last;
          end
        end else begin
          o_rd_valid <= inflight;
          if (inflight) begin
            o_rd_data <= ram_dout;
            o_rd_last <= inflight_last;
          end
        end
      end else if (inflight) begin
        skid_valid <= 1'b1;
        skid_data  <= ram_dout;
        skid_last  <= inflight_last;
      end
    end
  end

  fmap_dp_ram #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (i_clk),
    .wr_en   (wr_en_c),
    .wr_addr (wr_addr),
    .wr_data (i_wr_data),
    .rd_en   (issue_c),
    .rd_addr (rd_addr_c),
    .rd_dout (ram_dout)
  );

endmodule

// File: tb/tb_fmap_window_buffer.sv
// Bench: two buffers (K=5/S=1 and K=4/S=2) share stimulus; each is checked against a window model.
module tb_fmap_window_buffer;

  localparam int unsigned W = 48;
  typedef logic [W:0] beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         wr_valid = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         rd_ready = 1'b0;

  logic         wr_ready_a, rd_valid_a, rd_last_a, rd_done_a, busy_a;
  logic [W-1:0] rd_data_a;
  logic         wr_ready_b, rd_valid_b, rd_last_b, rd_done_b, busy_b;
  logic [W-1:0] rd_data_b;

  always #5 clk = ~clk;

  fmap_window_buffer dut_a (
    .i_clk(clk), .i_rst(rst_n), .i_flush(flush), .i_wr_valid(wr_valid), .i_wr_data(wr_data),
    .o_wr_ready(wr_ready_a), .o_rd_data(rd_data_a), .o_rd_valid(rd_valid_a), .i_rd_ready(rd_ready),
    .o_rd_last(rd_last_a), .o_rd_done(rd_done_a), .o_busy(busy_a)
  );

  fmap_window_buffer #(.K(4), .STRIDE(2)) dut_b (
    .i_clk(clk), .i_rst(rst_n), .i_flush(flush), .i_wr_valid(wr_valid), .i_wr_data(wr_data),
    .o_wr_ready(wr_ready_b), .o_rd_data(rd_data_b), .o_rd_valid(rd_valid_b), .i_rd_ready(rd_ready),
    .o_rd_last(rd_last_b), .o_rd_done(rd_done_b), .o_busy(busy_b)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  logic [W-1:0] map [144];
  beat_t exp0[$];
  beat_t exp1[$];
  int    idx[2], ndone[2], first_cyc[2], last_cyc[2], busy_cyc[2];
  bit    first_pend[2], prev_stall[2], prev_busy[2];
  beat_t prev_beat[2];

  int lit_a [25] = '{0, 1, 2, 3, 4, 12, 13, 14, 15, 16, 24, 25, 26, 27, 28,
                     36, 37, 38, 39, 40, 48, 49, 50, 51, 52};
  int lit_b [5]  = '{26, 27, 28, 29, 38};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [W-1:0] word(input int i, input int base);
    return {16'(i + base + 200), 16'(i + base + 100), 16'(i + base)};
  endfunction

  task automatic set_map(input int base);
    for (int i = 0; i < 144; i++) map[i] = word(i, base);
  endtask

  // Expected element stream: windows row-major, elements ky outer / kx inner.
  task automatic build_exp(input int d, input int k, input int s);
    int ow, oh;
    beat_t b;
    ow = (12 - k) / s + 1;
    oh = (12 - k) / s + 1;
    if (d == 0) exp0.delete(); else exp1.delete();
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++)
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++) begin
            b = {1'((ky == k - 1) && (kx == k - 1)), map[(oy * s + ky) * 12 + ox * s + kx]};
            if (d == 0) exp0.push_back(b); else exp1.push_back(b);
          end
  endtask

  task automatic arm();
    build_exp(0, 5, 1);
    build_exp(1, 4, 2);
    for (int d = 0; d < 2; d++) begin
      idx[d] = 0; ndone[d] = 0; prev_stall[d] = 1'b0;
      first_cyc[d] = -1; last_cyc[d] = -1;
    end
    chk_en = 1'b1;
  endtask

  task automatic chk_dut(input int d, input logic v, input logic [W-1:0] data, input logic last,
                         input logic done, input logic wrr, input logic busy);
    beat_t cur, e;
    int n;
    cur = {last, data};
    if (busy && !prev_busy[d]) begin
      busy_cyc[d] = cyc;
      first_pend[d] = 1'b1;
    end
    prev_busy[d] = busy;
    if (!chk_en) begin
      prev_stall[d] = 1'b0;
      return;
    end
    n = (d == 0) ? exp0.size() : exp1.size();
    if (v && first_pend[d]) begin
      check($sformatf("first_valid_latency%0d", d), 64'(cyc - busy_cyc[d]), 64'd2);
      first_pend[d] = 1'b0;
    end
    if (prev_stall[d]) begin
      check($sformatf("stall_valid%0d", d), 64'(v), 64'd1);
      if (v) check($sformatf("stall_hold%0d", d), 64'(cur), 64'(prev_beat[d]));
    end
    if (v && rd_ready) begin
      if (idx[d] < n) begin
        e = (d == 0) ? exp0[idx[d]] : exp1[idx[d]];
        check($sformatf("beat%0d[%0d]", d, idx[d]), 64'(cur), 64'(e));
      end else begin
        check($sformatf("extra_beat%0d", d), 64'(idx[d]), 64'(n - 1));
      end
      if (idx[d] == 0) first_cyc[d] = cyc;
      last_cyc[d] = cyc;
      idx[d]++;
    end
    prev_stall[d] = v && !rd_ready;
    prev_beat[d]  = cur;
    if (done) begin
      check($sformatf("done_pos%0d", d), 64'(idx[d]), 64'(n));
      check($sformatf("done_latency%0d", d), 64'(cyc - last_cyc[d]), 64'd1);
      check($sformatf("done_wr_ready%0d", d), 64'(wrr), 64'd1);
      ndone[d]++;
    end
  endtask

  // Single compare process, sampling mid-cycle.
  always @(negedge clk) begin
    cyc++;
    chk_dut(0, rd_valid_a, rd_data_a, rd_last_a, rd_done_a, wr_ready_a, busy_a);
    chk_dut(1, rd_valid_b, rd_data_b, rd_last_b, rd_done_b, wr_ready_b, busy_b);
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_ready_a"}, 64'(wr_ready_a), 64'd1);
    check({tag, "_rd_valid_a"}, 64'(rd_valid_a), 64'd0);
    check({tag, "_rd_last_a"},  64'(rd_last_a),  64'd0);
    check({tag, "_rd_done_a"},  64'(rd_done_a),  64'd0);
    check({tag, "_busy_a"},     64'(busy_a),     64'd0);
    check({tag, "_rd_data_a"},  64'(rd_data_a),  64'd0);
    check({tag, "_wr_ready_b"}, 64'(wr_ready_b), 64'd1);
    check({tag, "_rd_valid_b"}, 64'(rd_valid_b), 64'd0);
    check({tag, "_rd_last_b"},  64'(rd_last_b),  64'd0);
    check({tag, "_rd_done_b"},  64'(rd_done_b),  64'd0);
    check({tag, "_busy_b"},     64'(busy_b),     64'd0);
    check({tag, "_rd_data_b"},  64'(rd_data_b),  64'd0);
  endtask

  // Write the current map; optional random idle cycles between words.
  task automatic fill(input bit gaps);
    check("fill_start_ready_a", 64'(wr_ready_a), 64'd1);
    check("fill_start_ready_b", 64'(wr_ready_b), 64'd1);
    for (int i = 0; i < 144; i++) begin
      if (gaps) begin
        while ($urandom_range(3) == 0) begin
          wr_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      if (i == 143) check("last_write_ready_a", 64'(wr_ready_a), 64'd1);
      wr_valid = 1'b1;
      wr_data  = map[i];
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    check("wr_ready_fall_a", 64'(wr_ready_a), 64'd0);
    check("wr_ready_fall_b", 64'(wr_ready_b), 64'd0);
    check("busy_rise_a", 64'(busy_a), 64'd1);
    check("busy_rise_b", 64'(busy_b), 64'd1);
  endtask

  task automatic run_read(input int pct, input int budget);
    int n;
    n = 0;
    rd_ready = (pct >= 100);
    while (!(ndone[0] >= 1 && ndone[1] >= 1) && n < budget) begin
      @(posedge clk); #1;
      rd_ready = (pct >= 100) ? 1'b1 : ($urandom_range(99) < unsigned'(pct));
      n++;
    end
    repeat (4) begin
      @(posedge clk); #1;
      rd_ready = $urandom_range(1);
    end
    rd_ready = 1'b0;
    check("beats_a", 64'(idx[0]), 64'd1600);
    check("beats_b", 64'(idx[1]), 64'd400);
    check("done_count_a", 64'(ndone[0]), 64'd1);
    check("done_count_b", 64'(ndone[1]), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t t;
    int n;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Pin the model against hand-derived values.
    set_map(0);
    arm();
    check("model_size_a", 64'(exp0.size()), 64'd1600);
    check("model_size_b", 64'(exp1.size()), 64'd400);
    for (int i = 0; i < 25; i++) begin
      t = exp0[i];
      check($sformatf("model_first_window[%0d]", i), 64'(t[15:0]), 64'(lit_a[i]));
    end
    t = exp0[24];   check("model_last_flag_24", 64'(t[W]), 64'd1);
    t = exp0[23];   check("model_last_flag_23", 64'(t[W]), 64'd0);
    t = exp0[1575]; check("model_win63_start", 64'(t[15:0]), 64'd91);
    t = exp0[1599]; check("model_win63_end", 64'(t[15:0]), 64'd143);
    for (int i = 0; i < 5; i++) begin
      t = exp1[96 + i];
      check($sformatf("model_b_win11[%0d]", i), 64'(t[15:0]), 64'(lit_b[i]));
    end
    t = exp1[399];  check("model_b_last", 64'(t[15:0]), 64'd143);

    // Full-rate readout.
    rd_ready = 1'b1;
    fill(1'b0);
    run_read(100, 4000);
    check("contiguous_a", 64'(last_cyc[0] - first_cyc[0]), 64'd1599);
    check("contiguous_b", 64'(last_cyc[1] - first_cyc[1]), 64'd399);

    // Random backpressure.
    arm();
    fill(1'b0);
    run_read(50, 10000);

    // Flush in the middle of a readout.
    set_map(7000);
    arm();
    fill(1'b0);
    repeat (100) begin
      @(posedge clk); #1;
      rd_ready = $urandom_range(1);
    end
    chk_en = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("rd_flush_valid_a", 64'(rd_valid_a), 64'd0);
    check("rd_flush_valid_b", 64'(rd_valid_b), 64'd0);
    check("rd_flush_busy_a", 64'(busy_a), 64'd0);
    check("rd_flush_wr_ready_b", 64'(wr_ready_b), 64'd1);
    repeat (3) begin
      @(posedge clk); #1;
      check("rd_flush_no_done", 64'(rd_done_a | rd_done_b | rd_valid_a | rd_valid_b), 64'd0);
    end
    rd_ready = 1'b0;

    // Flush during fill, colliding with a write.
    set_map(5000);
    wr_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      wr_data = map[i];
      @(posedge clk); #1;
    end
    wr_data = map[50];
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wr_valid = 1'b0;
    check("fill_flush_wr_ready_a", 64'(wr_ready_a), 64'd1);
    check("fill_flush_busy_a", 64'(busy_a), 64'd0);
    set_map(3000);
    arm();
    fill(1'b1);
    run_read(50, 10000);

    // Asynchronous reset mid-readout, then a fresh map.
    set_map(1000);
    arm();
    fill(1'b0);
    rd_ready = 1'b1;
    n = 0;
    while (idx[0] < 700 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("reached_700_beats", 64'(idx[0] >= 700), 64'd1);
    chk_en = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_wr_ready_a", 64'(wr_ready_a), 64'd1);
    check("post_reset_wr_ready_b", 64'(wr_ready_b), 64'd1);
    set_map(2000);
    arm();
    fill(1'b0);
    run_read(70, 10000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
